// File: rtl/io_tx_l2_sequencer_if.sv
// ---------------------------------------------------------------------------
// io_tx_l2_sequencer_if
// Groups the signals of the TX L2 sequencer that face the channel register
// files, the TX FIFOs and the L2 read arbiter.
//   cfg_*  : per-channel transfer setup / status (flattened, channel c at slice c)
//   ch_*   : FIFO request and the one-cycle grant with its frame markers
//   l2_*   : single L2 read-request port
// The slave modport is the sequencer's view; master is the view of whatever
// drives it (register file / FIFOs / L2 arbiter, or a testbench).
// ---------------------------------------------------------------------------
interface io_tx_l2_sequencer_if #(
  parameter int N_CH       = 4,
  parameter int L2_AWIDTH  = 32,
  parameter int TRANS_SIZE = 16
);
  logic [N_CH*L2_AWIDTH-1:0]  cfg_startaddr_i;
  logic [N_CH*TRANS_SIZE-1:0] cfg_size_i;
  logic [N_CH-1:0]            cfg_en_i;
  logic [N_CH-1:0]            cfg_clr_i;
  logic [N_CH-1:0]            cfg_busy_o;
  logic [N_CH-1:0]            ch_req_i;
  logic [N_CH-1:0]            ch_gnt_o;
  logic [N_CH-1:0]            ch_sof_o;
  logic [N_CH-1:0]            ch_eof_o;
  logic [N_CH-1:0]            ch_done_o;
  logic                       l2_req_o;
  logic [L2_AWIDTH-1:0]       l2_addr_o;
  logic                       l2_gnt_i;

  modport slave (
    input  cfg_startaddr_i, cfg_size_i, cfg_en_i, cfg_clr_i, ch_req_i, l2_gnt_i,
    output cfg_busy_o, ch_gnt_o, ch_sof_o, ch_eof_o, ch_done_o, l2_req_o, l2_addr_o
  );

  modport master (
    output cfg_startaddr_i, cfg_size_i, cfg_en_i, cfg_clr_i, ch_req_i, l2_gnt_i,
    input  cfg_busy_o, ch_gnt_o, ch_sof_o, ch_eof_o, ch_done_o, l2_req_o, l2_addr_o
  );
endinterface

// File: rtl/io_tx_l2_sequencer.sv
// ---------------------------------------------------------------------------
// io_tx_l2_sequencer
// Shares one L2 read-request port among N_CH uDMA TX channels. Each channel
// holds a word-aligned transfer (address, remaining bytes); while its FIFO
// requests, a round-robin arbiter issues one word read at a time and returns
// a one-cycle grant tagged with start/end-of-frame so the FIFO can mark data.
// Ports:
//   clk_i  : clock
//   rstn_i : asynchronous active-low reset
//   bus    : slave modport of io_tx_l2_sequencer_if (cfg_*, ch_*, l2_*)
// ---------------------------------------------------------------------------
module io_tx_l2_sequencer #(
  parameter int N_CH       = 4,
  parameter int L2_AWIDTH  = 32,
  parameter int TRANS_SIZE = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  io_tx_l2_sequencer_if.slave      bus
);

  localparam int CW = $clog2(N_CH);

  typedef enum logic {ARB, REQ} arb_state_e;

  arb_state_e           state_q, state_d;
  logic [CW-1:0]        win_q, win_d;
  logic [CW-1:0]        ptr_q, ptr_d;
  logic [L2_AWIDTH-1:0] l2_addr_q, l2_addr_d;
  // Set when the current winner is cleared while its request is outstanding;
  // the eventual L2 grant is then swallowed.
  logic                 abort_q, abort_d;

  logic [N_CH-1:0]      ch_busy, elig, gnt_v, sof_v, eof_v;
  logic [L2_AWIDTH-1:0] ch_addr [N_CH];
  logic                 take;
  logic                 found;
  logic [CW-1:0]        pick, idx;

  // ------------------------------------------------------------------ channels
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic                  busy_q, first_q;
    logic [L2_AWIDTH-1:0]  addr_q;
    logic [TRANS_SIZE-1:0] rem_q;
    logic [TRANS_SIZE-1:0] size_rnd;
    logic [L2_AWIDTH-1:0]  start_aln;

    // Transfers move whole words only: drop the byte-offset bits.
    assign size_rnd  = bus.cfg_size_i[gi*TRANS_SIZE +: TRANS_SIZE] & ~TRANS_SIZE'(3);
    assign start_aln = bus.cfg_startaddr_i[gi*L2_AWIDTH +: L2_AWIDTH] & ~L2_AWIDTH'(3);

    assign elig[gi]    = busy_q & bus.ch_req_i[gi] & ~bus.cfg_clr_i[gi];
    assign gnt_v[gi]   = take && (win_q == CW'(gi));
    assign sof_v[gi]   = gnt_v[gi] & first_q;
    assign eof_v[gi]   = gnt_v[gi] & (rem_q == TRANS_SIZE'(4));
    assign ch_busy[gi] = busy_q;
    assign ch_addr[gi] = addr_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        busy_q  <= 1'b0;
        first_q <= 1'b0;
        addr_q  <= '0;
        rem_q   <= '0;
      end else if (bus.cfg_clr_i[gi]) begin
        busy_q <= 1'b0;
      end else if (gnt_v[gi]) begin
        addr_q  <= addr_q + L2_AWIDTH'(4);
        rem_q   <= rem_q - TRANS_SIZE'(4);
        first_q <= 1'b0;
        if (rem_q == TRANS_SIZE'(4)) busy_q <= 1'b0;
      end else if (bus.cfg_en_i[gi] && !busy_q && size_rnd != '0) begin
        addr_q  <= start_aln;
        rem_q   <= size_rnd;
        first_q <= 1'b1;
        busy_q  <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------- round-robin search
  // First eligible channel after the last winner, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = CW'((int'(ptr_q) + i) % N_CH);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // ---------------------------------------------------------------- arbiter
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    ptr_d     = ptr_q;
    l2_addr_d = l2_addr_q;
    abort_d   = abort_q;
    take      = 1'b0;
    case (state_q)
      ARB: begin
        if (found) begin
          state_d   = REQ;
          win_d     = pick;
          ptr_d     = pick;
          l2_addr_d = ch_addr[pick];
          abort_d   = 1'b0;
        end
      end
      REQ: begin
        abort_d = abort_q | bus.cfg_clr_i[win_q];
        if (bus.l2_gnt_i) begin
          // A clear in the grant cycle itself also aborts the word.
          take    = ~abort_q & ~bus.cfg_clr_i[win_q] & ch_busy[win_q];
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ARB;
      win_q     <= '0;
      ptr_q     <= CW'(N_CH - 1);
      l2_addr_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      ptr_q     <= ptr_d;
      l2_addr_q <= l2_addr_d;
      abort_q   <= abort_d;
    end
  end

  assign bus.cfg_busy_o = ch_busy;
  assign bus.ch_gnt_o   = gnt_v;
  assign bus.ch_sof_o   = sof_v;
  assign bus.ch_eof_o   = eof_v;
  assign bus.ch_done_o  = eof_v;
  assign bus.l2_req_o   = (state_q == REQ);
  assign bus.l2_addr_o  = l2_addr_q;

endmodule

// File: tb/tb_io_tx_l2_sequencer.sv
module tb_io_tx_l2_sequencer;
  localparam int N_CH = 4;
  localparam int AW   = 32;
  localparam int TS   = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  io_tx_l2_sequencer_if #(.N_CH(N_CH), .L2_AWIDTH(AW), .TRANS_SIZE(TS)) bus ();

  io_tx_l2_sequencer #(.N_CH(N_CH), .L2_AWIDTH(AW), .TRANS_SIZE(TS)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: each channel is a run of words still to be fetched;
  // the port is either idle or owned by one pending request.
  // ------------------------------------------------------------------
  bit              m_busy  [N_CH];
  logic [AW-1:0]   m_addr  [N_CH];
  int              m_words [N_CH];
  bit              m_first [N_CH];
  bit              m_pend, m_abort, granted, hit;
  int              m_win, m_ptr, gw, cand;
  logic [AW-1:0]   m_l2addr;
  logic [N_CH-1:0] e_gnt, e_sof, e_eof, e_busy;

  always @(negedge clk) begin
    if (!rstn) begin
      for (int c = 0; c < N_CH; c++) begin
        m_busy[c] = 0; m_addr[c] = '0; m_words[c] = 0; m_first[c] = 0;
      end
      m_pend = 0; m_abort = 0; m_win = 0; m_ptr = N_CH - 1; m_l2addr = '0;
    end else begin
      granted = m_pend && bus.l2_gnt_i && !m_abort && !bus.cfg_clr_i[m_win] && m_busy[m_win];
      e_gnt = '0; e_sof = '0; e_eof = '0;
      if (granted) begin
        e_gnt[m_win] = 1'b1;
        e_sof[m_win] = m_first[m_win];
        e_eof[m_win] = (m_words[m_win] == 1);
      end
      for (int c = 0; c < N_CH; c++) e_busy[c] = m_busy[c];
      chk("busy",    bus.cfg_busy_o, e_busy);
      chk("l2_req",  bus.l2_req_o, m_pend);
      if (m_pend) chk("l2_addr", bus.l2_addr_o, m_l2addr);
      chk("ch_gnt",  bus.ch_gnt_o, e_gnt);
      chk("ch_sof",  bus.ch_sof_o & bus.ch_gnt_o, e_sof);
      chk("ch_eof",  bus.ch_eof_o & bus.ch_gnt_o, e_eof);
      chk("ch_done", bus.ch_done_o, e_eof);

      gw = m_win;
      if (m_pend) begin
        if (bus.cfg_clr_i[m_win]) m_abort = 1;
        if (bus.l2_gnt_i) m_pend = 0;
      end else begin
        hit = 0;
        for (int k = 1; k <= N_CH; k++) begin
          cand = (m_ptr + k) % N_CH;
          if (!hit && m_busy[cand] && bus.ch_req_i[cand] && !bus.cfg_clr_i[cand]) begin
            hit = 1; m_pend = 1; m_win = cand; m_ptr = cand;
            m_l2addr = m_addr[cand]; m_abort = 0;
          end
        end
      end
      for (int c = 0; c < N_CH; c++) begin
        if (bus.cfg_clr_i[c]) m_busy[c] = 0;
        else if (granted && c == gw) begin
          m_addr[c] = m_addr[c] + 4;
          m_words[c]--;
          m_first[c] = 0;
          if (m_words[c] == 0) m_busy[c] = 0;
        end else if (bus.cfg_en_i[c] && !m_busy[c] && (bus.cfg_size_i[c*TS +: TS] >> 2) != 0) begin
          m_addr[c]  = bus.cfg_startaddr_i[c*AW +: AW] & ~32'h3;
          m_words[c] = int'(bus.cfg_size_i[c*TS +: TS] >> 2);
          m_first[c] = 1;
          m_busy[c]  = 1;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus helpers
  // ------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.cfg_en_i = '0; bus.cfg_clr_i = '0; bus.ch_req_i = '0; bus.l2_gnt_i = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    next_cycle();
    next_cycle();
    rstn = 1'b1;
  endtask

  task automatic set_cfg(input int c, input logic [AW-1:0] a, input logic [TS-1:0] s);
    bus.cfg_startaddr_i[c*AW +: AW] = a;
    bus.cfg_size_i[c*TS +: TS]      = s;
  endtask

  function automatic int onehot_idx(input logic [N_CH-1:0] v);
    int r = -1;
    for (int i = 0; i < N_CH; i++) if (v[i]) r = i;
    return r;
  endfunction

  int            ng, n_rand_gnt;
  int            g_cyc [8];
  logic [AW-1:0] g_addr[8];
  int            g_ch  [8];
  bit            g_sof [8];
  bit            g_eof [8];
  int            exp_cyc[3]  = '{2, 4, 6};
  logic [AW-1:0] exp_addr[3] = '{32'h1000, 32'h1004, 32'h1008};

  task automatic log_grant(input int k);
    if (bus.ch_gnt_o != '0 && ng < 8) begin
      g_cyc[ng]  = k;
      g_addr[ng] = bus.l2_addr_o;
      g_ch[ng]   = onehot_idx(bus.ch_gnt_o);
      g_sof[ng]  = |(bus.ch_sof_o & bus.ch_gnt_o);
      g_eof[ng]  = |(bus.ch_eof_o & bus.ch_gnt_o);
      ng++;
    end
  endtask

  initial begin
    bus.cfg_startaddr_i = '0;
    bus.cfg_size_i      = '0;
    idle_inputs();
    next_cycle();
    @(negedge clk);
    chk("reset busy", bus.cfg_busy_o, 0);
    chk("reset l2_req", bus.l2_req_o, 0);
    chk("reset ch_gnt", bus.ch_gnt_o, 0);
    chk("reset ch_done", bus.ch_done_o, 0);

    // 1: single channel, three words
    do_reset();
    set_cfg(0, 32'h1000, 16'd12);
    bus.ch_req_i = 4'b0001; bus.l2_gnt_i = 1'b1;
    ng = 0;
    for (int k = 0; k < 8; k++) begin
      bus.cfg_en_i = (k == 0) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      log_grant(k);
      if (k == 6) chk("t1 busy before drop", bus.cfg_busy_o[0], 1);
      if (k == 7) chk("t1 busy after done", bus.cfg_busy_o[0], 0);
      next_cycle();
    end
    chk("t1 grant count", ng, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1 grant cycle", g_cyc[i], exp_cyc[i]);
      chk("t1 grant addr", g_addr[i], exp_addr[i]);
      chk("t1 sof", g_sof[i], (i == 0));
      chk("t1 eof", g_eof[i], (i == 2));
    end

    // 2: four channels round-robin
    do_reset();
    for (int c = 0; c < N_CH; c++) set_cfg(c, 32'h2000 + 32'(c) * 32'h100, 16'd8);
    bus.ch_req_i = 4'b1111; bus.l2_gnt_i = 1'b1;
    ng = 0;
    for (int k = 0; k < 20; k++) begin
      bus.cfg_en_i = (k == 0) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      log_grant(k);
      next_cycle();
    end
    chk("t2 grant count", ng, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t2 order", g_ch[i], i % 4);
      chk("t2 sof", g_sof[i], (i < 4));
      chk("t2 eof", g_eof[i], (i >= 4));
    end

    // 3: L2 back-pressure keeps the request stable
    do_reset();
    set_cfg(1, 32'h3000, 16'd8);
    set_cfg(2, 32'h4000, 16'd8);
    bus.ch_req_i = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      bus.cfg_en_i = (k == 0) ? 4'b0110 : 4'b0000;
      bus.l2_gnt_i = (k >= 7);
      @(negedge clk);
      if (k >= 2 && k <= 6) begin
        chk("t3 req held", bus.l2_req_o, 1);
        chk("t3 addr held", bus.l2_addr_o, 32'h3000);
        chk("t3 no gnt", bus.ch_gnt_o, 0);
      end
      if (k == 7) chk("t3 ch1 granted", bus.ch_gnt_o, 4'b0010);
      if (k == 9) begin
        chk("t3 ch2 next", bus.ch_gnt_o, 4'b0100);
        chk("t3 ch2 addr", bus.l2_addr_o, 32'h4000);
      end
      next_cycle();
    end

    // 4: abort while the request is outstanding
    do_reset();
    set_cfg(1, 32'h5000, 16'd8);
    bus.ch_req_i = 4'b0010;
    for (int k = 0; k < 7; k++) begin
      bus.cfg_en_i  = (k == 0) ? 4'b0010 : 4'b0000;
      bus.cfg_clr_i = (k == 3) ? 4'b0010 : 4'b0000;
      bus.l2_gnt_i  = (k == 4);
      @(negedge clk);
      if (k == 4) begin
        chk("t4 absorbed gnt", bus.ch_gnt_o, 0);
        chk("t4 no done", bus.ch_done_o, 0);
        chk("t4 busy cleared", bus.cfg_busy_o[1], 0);
      end
      if (k == 5 || k == 6) chk("t4 back to idle", bus.l2_req_o, 0);
      next_cycle();
    end

    // 5a: size 3 rounds to zero and is ignored
    do_reset();
    set_cfg(2, 32'h6000, 16'd3);
    bus.ch_req_i = 4'b0100; bus.l2_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.cfg_en_i = (k == 0) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (k == 1 || k == 3) chk("t5 size3 ignored", bus.cfg_busy_o, 0);
      next_cycle();
    end
    // 5b: size 4 is a single word with both markers
    set_cfg(3, 32'h7003, 16'd4);
    bus.ch_req_i = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      bus.cfg_en_i = (k == 0) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      if (k == 2) begin
        chk("t5 single gnt", bus.ch_gnt_o, 4'b1000);
        chk("t5 single sof", bus.ch_sof_o, 4'b1000);
        chk("t5 single eof", bus.ch_eof_o, 4'b1000);
        chk("t5 single addr", bus.l2_addr_o, 32'h7000);
      end
      if (k == 3) chk("t5 single busy drop", bus.cfg_busy_o[3], 0);
      next_cycle();
    end
    // 5c: re-start while busy changes nothing
    set_cfg(0, 32'h8000, 16'd8);
    bus.ch_req_i = '0;
    ng = 0;
    for (int k = 0; k < 12; k++) begin
      bus.cfg_en_i = (k == 0 || k == 2) ? 4'b0001 : 4'b0000;
      if (k == 2) set_cfg(0, 32'h9000, 16'd16);
      bus.ch_req_i = (k >= 4) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      log_grant(k);
      next_cycle();
    end
    chk("t5 busy-en grant count", ng, 2);
    chk("t5 busy-en addr", g_addr[0], 32'h8000);
    chk("t5 busy-en eof", g_eof[1], 1);

    // 6: asynchronous reset during a grant
    do_reset();
    set_cfg(0, 32'hA000, 16'd8);
    set_cfg(1, 32'hB000, 16'd8);
    bus.ch_req_i = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      bus.cfg_en_i = (k == 0) ? 4'b0011 : 4'b0000;
      bus.l2_gnt_i = (k == 3);
      @(negedge clk);
      if (k == 3) chk("t6 gnt before reset", bus.ch_gnt_o, 4'b0001);
      if (k < 3) next_cycle();
    end
    #1 rstn = 1'b0;
    #1;
    chk("t6 reset l2_req", bus.l2_req_o, 0);
    chk("t6 reset busy", bus.cfg_busy_o, 0);
    chk("t6 reset gnt", bus.ch_gnt_o, 0);
    chk("t6 reset sof/eof/done", {bus.ch_sof_o, bus.ch_eof_o, bus.ch_done_o}, 0);
    idle_inputs();
    next_cycle();
    next_cycle();
    rstn = 1'b1;
    set_cfg(0, 32'hD000, 16'd4);
    set_cfg(3, 32'hC000, 16'd4);
    bus.ch_req_i = 4'b1001; bus.l2_gnt_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.cfg_en_i = (k == 0) ? 4'b1001 : 4'b0000;
      @(negedge clk);
      if (k == 2) begin
        chk("t6 ch0 first", bus.ch_gnt_o, 4'b0001);
        chk("t6 ch0 addr", bus.l2_addr_o, 32'hD000);
      end
      if (k == 4) chk("t6 ch3 second", bus.ch_gnt_o, 4'b1000);
      next_cycle();
    end

    // Randomized traffic against the model
    do_reset();
    n_rand_gnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 3) == 0)
          set_cfg(c, 32'hFFFF_FFE0 + 32'($urandom_range(0, 31)), 16'($urandom_range(0, 40)));
        else
          set_cfg(c, 32'($urandom), 16'($urandom_range(0, 40)));
        bus.cfg_en_i[c]  = ($urandom_range(0, 7) == 0);
        bus.cfg_clr_i[c] = ($urandom_range(0, 63) == 0);
        bus.ch_req_i[c]  = ($urandom_range(0, 3) != 0);
      end
      bus.l2_gnt_i = ($urandom_range(0, 2) != 0);
      rstn = (cyc != 1500);
      @(negedge clk);
      if (bus.ch_gnt_o != '0) n_rand_gnt++;
      next_cycle();
    end
    rstn = 1'b1;
    chk("random traffic produced grants", (n_rand_gnt > 100), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_tx_l2_sequencer.md
Name: io_tx_l2_sequencer

Overview:
Sequences and shares one L2 read-request port among N_CH uDMA TX channels, each fronted by a marked TX FIFO.
- Per channel: holds a transfer (start address, byte size) and issues word reads in round-robin order while that channel's FIFO requests.
- Returns a one-cycle grant to the FIFO, with start-of-frame on the first word and end-of-frame on the last word, so the FIFO can tag the matching data.
- Sits between the channel register files, the TX FIFOs and the L2 read arbiter.

Parameters:
N_CH, 4, number of TX channels (≥2).
L2_AWIDTH, 32, L2 byte-address width.
TRANS_SIZE, 16, width of the per-channel byte-size counter.

Ports:
clk_i  in  1  clock.
rstn_i  in  1  asynchronous active-low reset.
cfg_startaddr_i  in  N_CH*L2_AWIDTH  per-channel start byte address; channel c at slice c.
cfg_size_i  in  N_CH*TRANS_SIZE  per-channel byte count.
cfg_en_i  in  N_CH  per-channel start pulse.
cfg_clr_i  in  N_CH  per-channel abort pulse.
cfg_busy_o  out  N_CH  channel has a transfer loaded.
ch_req_i  in  N_CH  FIFO can accept a further in-flight word.
ch_gnt_o  out  N_CH  one-cycle grant to the FIFO.
ch_sof_o  out  N_CH  first word of the transfer; valid with ch_gnt_o.
ch_eof_o  out  N_CH  last word of the transfer; valid with ch_gnt_o.
ch_done_o  out  N_CH  transfer-complete pulse.
l2_req_o  out  1  L2 read request.
l2_addr_o  out  L2_AWIDTH  word-aligned L2 address.
l2_gnt_i  in  1  L2 accepts the request.

Behaviour:
- Reset values: all outputs 0; per-channel state IDLE; RR pointer = N_CH-1, so channel 0 wins first; arbiter state ARB.
- Channel start:
  - Size is rounded down to a multiple of 4 (bits [1:0] ignored).
  - cfg_en_i[c] while channel c is IDLE and rounded size ≠ 0: load addr = {startaddr[AW-1:2],2'b00}, rem = rounded size, first = 1; next cycle busy = 1.
  - cfg_en_i[c] is ignored when the channel is busy or the rounded size is 0.
- Channel abort:
  - cfg_clr_i[c] returns channel c to IDLE next cycle with busy = 0 and no done pulse.
  - cfg_clr_i wins over a simultaneous cfg_en_i.
- Eligibility: channel c is eligible when busy[c] & ch_req_i[c] & ~cfg_clr_i[c].
- Arbiter FSM, ARB state:
  - If any channel is eligible, select the first eligible channel searching from ptr+1 upward with wrap-around.
  - Register winner, l2_addr_o = addr[winner] and l2_req_o = 1; go to REQ; ptr = winner.
  - Otherwise stay in ARB.
- Arbiter FSM, REQ state:
  - l2_req_o and l2_addr_o are held stable until l2_gnt_i; no withdrawal.
  - On l2_gnt_i with the winner still busy, in the same cycle:
    - assert ch_gnt_o[winner];
    - ch_sof_o[winner] = first;
    - ch_eof_o[winner] = (rem == 4), with ch_done_o[winner] asserted at the same time.
  - Next cycle: addr += 4, rem -= 4, first = 0, l2_req_o = 0, state ARB. If rem reached 0, the channel goes IDLE with busy = 0.
  - On l2_gnt_i when the winner was cleared during REQ: the grant is absorbed, no ch_* outputs assert, return to ARB.
- Throughput: at most one grant every 2 cycles; at most one ch_gnt_o bit set per cycle.
- Address arithmetic: wraps modulo 2^L2_AWIDTH with no error.
- Overlapping transfers: a channel may be restarted on the cycle after its done pulse.
- Reset mid-transfer: all state is cleared immediately and asynchronously.

Test Plan:
1. ch0 start addr 0x1000, size 12, ch_req_i[0] = 1, l2_gnt_i = 1 → l2_addr_o 0x1000, 0x1004, 0x1008 on cycles 2, 4, 6; sof with the first grant; eof and done with the third grant; busy[0] drops on the next cycle.
2. All 4 channels started with size 8, all requesting, gnt tied high → grant order 0, 1, 2, 3, 0, 1, 2, 3; each channel sees sof on its first grant and eof on its second.
3. ch1 in REQ, l2_gnt_i held low 5 cycles, ch2 requesting → l2_req_o and l2_addr_o stay stable for all 5 cycles; ch1 is granted when gnt rises; ch2 wins next.
4. cfg_clr_i[1] pulsed while ch1 is in REQ, then l2_gnt_i → no ch_gnt_o, no done; busy[1] = 0; arbiter returns to ARB.
5. Corner sizes: size 3 → start ignored, busy stays 0. Size 4 → a single grant with sof = eof = 1. cfg_en_i while busy → no change to addr or rem.
6. Reset asserted mid-REQ → l2_req_o, busy and all ch_* outputs are 0 immediately; after reset release, ch0 wins first.
